adsr_envelope_ctrl: RTL and testbench
=====================================

Name: adsr_envelope_ctrl

Overview:
- Envelope sequencer that drives the amplitude input of the synth ALU path.
- Takes the note gate plus the octave/amplitude/ADSR settings from the IO controller. Runs an IDLE/ATTACK/DECAY/SUSTAIN/RELEASE state machine on a slow tick.
- Outputs a 6-bit time-varying level that replaces the static amplitude at the ALUcontroller input.
- Also exposes the current state for LEDR/HEX debug.

Parameters:
- TICK_DIV, 50000, clk cycles per envelope tick (1 ms at 50 MHz); minimum 2.
- LEVEL_W, 6, width of the level, amplitude and rate fields.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- note_in  input  1  note gate; high = key held
- amplitude  input  6  peak level for ATTACK
- attack  input  6  level added per tick in ATTACK; 0 treated as 1
- decay  input  6  level subtracted per tick in DECAY; 0 = jump straight to sustain level
- sustain  input  6  sustain level, clamped to amplitude
- rel  input  6  level subtracted per tick in RELEASE; 0 treated as 1
- env_level  output  6  current envelope level, to the ALUcontroller amplitude input
- adsr_state  output  3  current state encoding
- active  output  1  high when adsr_state != IDLE
- tick  output  1  one-cycle tick pulse, for debug and bench sync

Behaviour:
- Reset (reset==0 at posedge clk):
  - env_level=0, adsr_state=IDLE, active=0, tick=0
  - tick counter=0, gate history register=0
  - Reset applies from any state, mid-envelope included.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the one cycle the counter equals TICK_DIV-1.
  - Free-running; not restarted by gate events.
- Gate edges:
  - note_in is registered once (gate_q). rise = note_in & ~gate_q; fall = ~note_in & gate_q.
  - Edges act on the same cycle they are detected, without waiting for a tick.
  - rise from any state goes to ATTACK. env_level keeps its current value (retrigger from the current level, no click).
  - fall from ATTACK, DECAY or SUSTAIN goes to RELEASE. fall in IDLE or RELEASE is ignored.
  - An edge takes priority over a tick update in the same cycle: the state changes and env_level holds for that cycle.
- Level updates: only on tick cycles with no edge. All arithmetic is 7-bit unsigned; sus_lvl = min(sustain, amplitude).
  - IDLE: env_level=0.
  - ATTACK:
    - sum = env + max(attack,1).
    - If sum >= amplitude: env=amplitude, go to DECAY. Otherwise env=sum.
    - attack=63 reaches peak in 1 tick. amplitude=0 gives env=0 then DECAY.
  - DECAY:
    - If decay==0 or env <= sus_lvl + decay: env=sus_lvl, go to SUSTAIN.
    - Otherwise env = env - decay.
  - SUSTAIN:
    - env=sus_lvl on every tick, so live changes to sustain or amplitude are tracked.
    - Stays here while the gate is held.
  - RELEASE:
    - If env <= max(rel,1): env=0, go to IDLE. Otherwise env = env - rel.
    - rel=63 means instant cutoff on the next tick.
- Input changes: new rate and level values take effect at the next tick. There is no latching at note-on.
- Timing: all outputs are registered. env_level changes 1 cycle after the qualifying tick or edge is sampled.
- The state encoding never leaves the five legal values. Any illegal encoding recovers to IDLE with env=0.

Decomposition:
- Shared package synth_pkg:
  - State localparams ST_IDLE=3'd0, ST_ATTACK=3'd1, ST_DECAY=3'd2, ST_SUSTAIN=3'd3, ST_RELEASE=3'd4.
  - LEVEL_W=6, LEVEL_MAX=6'd63.
  - Default TICK_DIV.
- Sub-module tick_divider(clk, reset, tick), parameterised by TICK_DIV. It is reused later for the PS2 auto-repeat.
- The FSM and level datapath stay in adsr_envelope_ctrl.

Test Plan (TICK_DIV=4 for simulation):
- Defaults (amp=63, att=63, dec=0, sus=63, rel=63), raise note_in -> ATTACK the next cycle, env=63 at the first tick, then DECAY, then SUSTAIN at env=63. Drop note_in -> RELEASE, then env=0 and IDLE at the next tick.
- amp=40, att=10, dec=5, sus=20, rel=7, gate held -> env per tick 10, 20, 30, 40 (DECAY), 35, 30, 25, 20 (SUSTAIN). Gate low -> 13, 6, 0 (IDLE).
- Retrigger: gate low at env=30 in RELEASE, high again 2 cycles later -> ATTACK resumes from the current level (30 - rel after one tick, else 30), with no drop to 0.
- Gate rise coincident with a tick cycle -> state goes to ATTACK that cycle, env unchanged. The first increment comes at the following tick.
- att=0, rel=0 -> both treated as step 1. amp=3: env 1, 2, 3. After gate low: 2, 1, 0, then IDLE.
- reset=0 asserted mid-DECAY -> the next cycle shows env=0, IDLE, active=0, and the tick counter restarts with tick 4 cycles after release of reset.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants for the synth envelope and tick logic
// Contents: level width, level ceiling, default tick divisor, ADSR state codes.
package synth_pkg;

    localparam int LEVEL_W = 6;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 6'd63;

    // 1 ms envelope tick at a 50 MHz system clock
    localparam int TICK_DIV_DEFAULT = 50000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
// Ports: clk (system clock), reset (sync, active-low), tick (high while the count is TICK_DIV-1).
module tick_divider #(
    parameter int TICK_DIV = synth_pkg::TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        // tick is registered alongside the count so it is high exactly while cnt_q == LAST
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/adsr_envelope_ctrl.sv
// rtl/adsr_envelope_ctrl.sv - ADSR envelope sequencer driving the ALU amplitude input
// Ports: clk, reset (sync, active-low), note_in (gate), amplitude/attack/decay/sustain/rel (6-bit settings),
//        env_level (6-bit level), adsr_state (3-bit state), active (state != IDLE), tick (envelope tick pulse).
module adsr_envelope_ctrl
    import synth_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               note_in,
    input  logic [LEVEL_W-1:0] amplitude,
    input  logic [LEVEL_W-1:0] attack,
    input  logic [LEVEL_W-1:0] decay,
    input  logic [LEVEL_W-1:0] sustain,
    input  logic [LEVEL_W-1:0] rel,
    output logic [LEVEL_W-1:0] env_level,
    output logic [2:0]         adsr_state,
    output logic               active,
    output logic               tick
);

    localparam int XW = LEVEL_W + 1;

    logic               tick_w;
    logic               gate_q;
    logic [2:0]         state_q, state_d;
    logic [LEVEL_W-1:0] env_q, env_d;
    logic               rise, fall;

    // one extra bit so sums and thresholds never wrap
    logic [XW-1:0] env_x, amp_x, att_x, dec_x, rel_x, sus_x, sum_x, dec_thr_x;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_w)
    );

    assign rise = note_in & ~gate_q;
    assign fall = ~note_in & gate_q;

    assign env_x     = {1'b0, env_q};
    assign amp_x     = {1'b0, amplitude};
    assign dec_x     = {1'b0, decay};
    // zero attack/release rates would stall the envelope, so they step by one instead
    assign att_x     = (attack == '0) ? XW'(1) : {1'b0, attack};
    assign rel_x     = (rel == '0) ? XW'(1) : {1'b0, rel};
    assign sus_x     = (sustain < amplitude) ? {1'b0, sustain} : {1'b0, amplitude};
    assign sum_x     = env_x + att_x;
    assign dec_thr_x = sus_x + dec_x;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (state_q > ST_RELEASE) begin
            state_d = ST_IDLE;
            env_d   = '0;
        end else if (rise) begin
            // retrigger keeps the current level to avoid an audible click
            state_d = ST_ATTACK;
        end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else if (tick_w) begin
            case (state_q)
                ST_IDLE: env_d = '0;
                ST_ATTACK: begin
                    if (sum_x >= amp_x) begin
                        env_d   = amplitude;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = sum_x[LEVEL_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (decay == '0 || env_x <= dec_thr_x) begin
                        env_d   = sus_x[LEVEL_W-1:0];
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_q - decay;
                    end
                end
                // re-evaluated every tick so live sustain/amplitude edits are followed
                ST_SUSTAIN: env_d = sus_x[LEVEL_W-1:0];
                ST_RELEASE: begin
                    if (env_x <= rel_x) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - rel_x[LEVEL_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gate_q  <= 1'b0;
            state_q <= ST_IDLE;
            env_q   <= '0;
        end else begin
            gate_q  <= note_in;
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    assign env_level  = env_q;
    assign adsr_state = state_q;
    assign active     = (state_q != ST_IDLE);
    assign tick       = tick_w;

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
// tb/tb_adsr_envelope_ctrl.sv - self-checking bench for adsr_envelope_ctrl
module tb_adsr_envelope_ctrl;

    localparam int TD = 4;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       note_in;
    logic [5:0] amplitude, attack, decay, sustain, rel;
    logic [5:0] env_level;
    logic [2:0] adsr_state;
    logic       active;
    logic       tick;

    int errors = 0;
    int checks = 0;

    // reference model state: envelope level, phase, clocks since reset, previous gate
    int m_env = 0;
    int m_st  = S_IDLE;
    int m_n   = 0;
    bit m_gate = 1'b0;

    typedef struct {
        bit rst;
        bit note;
        int amp, att, dec, sus, rel;
        int n;
        int env;
        int st;
        bit tk;
    } vec_t;

    vec_t tbl[$];
    int c_amp, c_att, c_dec, c_sus, c_rel;

    adsr_envelope_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .note_in    (note_in),
        .amplitude  (amplitude),
        .attack     (attack),
        .decay      (decay),
        .sustain    (sustain),
        .rel        (rel),
        .env_level  (env_level),
        .adsr_state (adsr_state),
        .active     (active),
        .tick       (tick)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
        end
    endfunction

    // envelope rules applied to the inputs present at a clock edge
    task automatic model_step();
        bit tk, rs, fl;
        int sus_l, a, r;
        if (!reset) begin
            m_env = 0; m_st = S_IDLE; m_n = 0; m_gate = 1'b0;
        end else begin
            tk = ((m_n % TD) == TD - 1);
            rs = note_in && !m_gate;
            fl = !note_in && m_gate;
            sus_l = (int'(sustain) < int'(amplitude)) ? int'(sustain) : int'(amplitude);
            a = (attack == 0) ? 1 : int'(attack);
            r = (rel == 0) ? 1 : int'(rel);
            if (rs) m_st = S_ATT;
            else if (fl && (m_st == S_ATT || m_st == S_DEC || m_st == S_SUS)) m_st = S_REL;
            else if (tk) begin
                if (m_st == S_IDLE) m_env = 0;
                else if (m_st == S_ATT) begin
                    if (m_env + a >= int'(amplitude)) begin m_env = int'(amplitude); m_st = S_DEC; end
                    else m_env = m_env + a;
                end else if (m_st == S_DEC) begin
                    if (decay == 0 || m_env <= sus_l + int'(decay)) begin m_env = sus_l; m_st = S_SUS; end
                    else m_env = m_env - int'(decay);
                end else if (m_st == S_SUS) m_env = sus_l;
                else begin
                    if (m_env <= r) begin m_env = 0; m_st = S_IDLE; end
                    else m_env = m_env - r;
                end
            end
            m_n++;
            m_gate = note_in;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_env", int'(env_level), m_env);
        chk("model_state", int'(adsr_state), m_st);
        chk("model_active", int'(active), (m_st != S_IDLE) ? 1 : 0);
        chk("model_tick", int'(tick), ((m_n % TD) == TD - 1) ? 1 : 0);
    endtask

    task automatic cfg(int a, int at, int d, int s, int r);
        c_amp = a; c_att = at; c_dec = d; c_sus = s; c_rel = r;
    endtask

    task automatic add(bit r, bit n, int cycles, int e, int st, bit tk);
        vec_t v;
        v.rst = r; v.note = n; v.amp = c_amp; v.att = c_att; v.dec = c_dec;
        v.sus = c_sus; v.rel = c_rel; v.n = cycles; v.env = e; v.st = st; v.tk = tk;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b0; note_in = 1'b0;
        amplitude = 0; attack = 0; decay = 0; sustain = 0; rel = 0;

        // stepped envelope: 10,20,30,40 then 35,30,25,20 then release 13,6,0
        cfg(40, 10, 5, 20, 7);
        add(0, 0, 1, 0, S_IDLE, 0);
        add(1, 1, 1, 0, S_ATT, 0);
        add(1, 1, 3, 10, S_ATT, 0);
        add(1, 1, 4, 20, S_ATT, 0);
        add(1, 1, 4, 30, S_ATT, 0);
        add(1, 1, 4, 40, S_DEC, 0);
        add(1, 1, 4, 35, S_DEC, 0);
        add(1, 1, 4, 30, S_DEC, 0);
        add(1, 1, 4, 25, S_DEC, 0);
        add(1, 1, 4, 20, S_SUS, 0);
        add(1, 0, 1, 20, S_REL, 0);
        add(1, 0, 3, 13, S_REL, 0);
        add(1, 0, 4, 6, S_REL, 0);
        add(1, 0, 4, 0, S_IDLE, 0);
        // zero attack/release rates step by one
        cfg(3, 0, 0, 3, 0);
        add(1, 1, 1, 0, S_ATT, 0);
        add(1, 1, 3, 1, S_ATT, 0);
        add(1, 1, 4, 2, S_ATT, 0);
        add(1, 1, 4, 3, S_DEC, 0);
        add(1, 1, 4, 3, S_SUS, 0);
        add(1, 0, 1, 3, S_REL, 0);
        add(1, 0, 3, 2, S_REL, 0);
        add(1, 0, 4, 1, S_REL, 0);
        add(1, 0, 4, 0, S_IDLE, 0);
        // full-scale defaults: instant attack and instant cutoff
        cfg(63, 63, 0, 63, 63);
        add(1, 1, 1, 0, S_ATT, 0);
        add(1, 1, 3, 63, S_DEC, 0);
        add(1, 1, 4, 63, S_SUS, 0);
        add(1, 0, 1, 63, S_REL, 0);
        add(1, 0, 3, 0, S_IDLE, 0);
        // gate rise on the tick cycle: state moves, level holds
        cfg(40, 10, 5, 20, 7);
        add(1, 0, 3, 0, S_IDLE, 1);
        add(1, 1, 1, 0, S_ATT, 0);
        add(1, 1, 4, 10, S_ATT, 0);
        add(1, 1, 4, 20, S_ATT, 0);
        add(1, 1, 4, 30, S_ATT, 0);
        // release at 30 then retrigger two cycles later from 30
        add(1, 0, 1, 30, S_REL, 0);
        add(1, 0, 1, 30, S_REL, 0);
        add(1, 1, 1, 30, S_ATT, 1);
        add(1, 1, 1, 40, S_DEC, 0);
        add(1, 1, 4, 35, S_DEC, 0);
        // reset mid-decay, then tick three edges after the reset edge
        add(0, 1, 1, 0, S_IDLE, 0);
        add(1, 0, 2, 0, S_IDLE, 0);
        add(1, 0, 1, 0, S_IDLE, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; note_in = tbl[i].note;
            amplitude = 6'(tbl[i].amp); attack = 6'(tbl[i].att); decay = 6'(tbl[i].dec);
            sustain = 6'(tbl[i].sus); rel = 6'(tbl[i].rel);
            repeat (tbl[i].n) cyc();
            chk($sformatf("vec%0d_env", i), int'(env_level), tbl[i].env);
            chk($sformatf("vec%0d_state", i), int'(adsr_state), tbl[i].st);
            chk($sformatf("vec%0d_tick", i), int'(tick), int'(tbl[i].tk));
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                amplitude = 6'($urandom_range(0, 63));
                attack = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 20));
                decay = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 20));
                sustain = 6'($urandom_range(0, 63));
                rel = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 15) == 0) note_in = ~note_in;
            reset = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
